// File: rtl/vga_frame_reader_if.sv
// vga_frame_reader_if: frame-buffer read port plus VGA pin bundle of the frame reader.
interface vga_frame_reader_if #(
    parameter int c_nb_img_pxls = 13,
    parameter int c_nb_buf      = 12
);
    logic [c_nb_img_pxls-1:0] frame_addr;
    logic [c_nb_buf-1:0]      frame_pxl;
    logic                     vga_hsync;
    logic                     vga_vsync;
    logic [3:0]               vga_red;
    logic [3:0]               vga_green;
    logic [3:0]               vga_blue;
    logic                     visible;
    logic                     end_frame;
    modport master (
        output frame_addr, vga_hsync, vga_vsync, vga_red, vga_green, vga_blue, visible, end_frame,
        input  frame_pxl
    );
    modport slave (
        input  frame_addr, vga_hsync, vga_vsync, vga_red, vga_green, vga_blue, visible, end_frame,
        output frame_pxl
    );
endinterface

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 640x480@60 VGA timing that reads an 8x-upscaled image from a sync buffer.
// Define VGA_BORDER_EN to paint a white one-pixel border around the active area.
module vga_frame_reader #(
    parameter int c_img_cols    = 80,
    parameter int c_img_rows    = 60,
    parameter int c_nb_img_pxls = 13,
    parameter int c_nb_buf      = 12
) (
    input  logic                clk,
    input  logic                rst,
    vga_frame_reader_if.master  bus
);
    localparam logic [9:0] h_act = 10'(c_img_cols * 8);
    localparam logic [9:0] v_act = 10'(c_img_rows * 8);
    logic [9:0]               hcnt, vcnt;
    logic [c_nb_img_pxls-1:0] line_base;
    logic                     h_last, f_last, active, hs_raw, vs_raw;
    logic                     act1, hs1, vs1;
    logic [11:0]              pix;
    assign h_last = hcnt == 10'd799;
    assign f_last = h_last && vcnt == 10'd524;
    assign active = hcnt < h_act && vcnt < v_act;
    assign hs_raw = !(hcnt >= 10'd656 && hcnt <= 10'd751);
    assign vs_raw = !(vcnt >= 10'd490 && vcnt <= 10'd491);
    // line_base tracks (vcnt>>3)*cols incrementally, so no multiplier is needed
    assign bus.frame_addr = active ? line_base + c_nb_img_pxls'(hcnt[9:3]) : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt      <= '0;
            vcnt      <= '0;
            line_base <= '0;
        end else begin
            hcnt <= h_last ? '0 : hcnt + 10'd1;
            if (h_last) begin
                vcnt      <= vcnt == 10'd524 ? '0 : vcnt + 10'd1;
                line_base <= f_last ? '0 :
                             (vcnt < v_act && vcnt[2:0] == 3'd7) ? line_base + c_nb_img_pxls'(c_img_cols) :
                             line_base;
            end
        end
    end
`ifdef VGA_BORDER_EN
    logic border, brd1;
    assign border = active && (hcnt == 10'd0 || hcnt == h_act - 10'd1 || vcnt == 10'd0 || vcnt == v_act - 10'd1);
    always_ff @(posedge clk) brd1 <= rst ? 1'b0 : border;
    assign pix = !act1 ? 12'h000 : brd1 ? 12'hfff : bus.frame_pxl[11:0];
`else
    assign pix = act1 ? bus.frame_pxl[11:0] : 12'h000;
`endif
    // stage 1 lines up with frame_pxl, stage 2 drives the pins
    always_ff @(posedge clk) begin
        if (rst) begin
            act1          <= 1'b0;
            hs1           <= 1'b1;
            vs1           <= 1'b1;
            bus.vga_hsync <= 1'b1;
            bus.vga_vsync <= 1'b1;
            bus.vga_red   <= '0;
            bus.vga_green <= '0;
            bus.vga_blue  <= '0;
            bus.visible   <= 1'b0;
            bus.end_frame <= 1'b0;
        end else begin
            act1          <= active;
            hs1           <= hs_raw;
            vs1           <= vs_raw;
            bus.vga_hsync <= hs1;
            bus.vga_vsync <= vs1;
            bus.vga_red   <= pix[11:8];
            bus.vga_green <= pix[7:4];
            bus.vga_blue  <= pix[3:0];
            bus.visible   <= act1;
            bus.end_frame <= f_last;
        end
    end
endmodule
